// File: rtl/uart_frame_encoder.sv
// Serialises a telemetry snapshot into an ASCII frame "$A:hh..,B:hh..*cc\r\n" written byte by
// byte into a UART FIFO. A frame is sent on a field change, on force_send, or on keepalive expiry.
module uart_frame_encoder #(
    parameter int unsigned NUM_FIELDS       = 8,
    parameter int unsigned FIELD_W          = 12,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned MIN_GAP_CYCLES   = 6_500_000,
    parameter int unsigned KEEPALIVE_CYCLES = 65_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields_in,
    input  logic                          force_send,
    input  logic                          tx_ready,
    input  logic                          tx_full,
    output logic [DATA_WIDTH-1:0]         uart_data,
    output logic                          uart_wr,
    output logic                          busy,
    output logic [15:0]                   frames_sent
);
    localparam int unsigned D        = (FIELD_W + 3) / 4;
    localparam int unsigned NIB_W    = 4 * D;
    localparam int unsigned FRAME_W  = NUM_FIELDS * FIELD_W;
    localparam int unsigned STAR_IDX = NUM_FIELDS * (D + 3);
    localparam int unsigned L        = STAR_IDX + 5;
    localparam int unsigned IDX_W    = $clog2(L);
    localparam int unsigned OFF_W    = $clog2(D + 3);
    localparam int unsigned FLD_W    = $clog2(NUM_FIELDS + 1);
    localparam int unsigned GAP_W    = (MIN_GAP_CYCLES > 0) ? $clog2(MIN_GAP_CYCLES + 1) : 1;
    localparam int unsigned KA_W     = (KEEPALIVE_CYCLES > 0) ? $clog2(KEEPALIVE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LATCH = 2'd1, S_SEND = 2'd2} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_W-1:0]    r_snap;
    logic [FRAME_W-1:0]    r_last_sent;
    logic                  r_force_pend;
    logic [IDX_W-1:0]      r_idx;
    logic [OFF_W-1:0]      r_off;
    logic [FLD_W-1:0]      r_fld;
    logic [7:0]            r_csum;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic                  r_gap_done;
    logic [KA_W-1:0]       r_ka_cnt;
    logic [DATA_WIDTH-1:0] r_uart_data;
    logic                  r_uart_wr;
    logic                  r_busy;
    logic [15:0]           r_frames_sent;

    logic                  w_wr_en;
    logic                  w_last;
    logic                  w_csum_upd;
    logic                  w_ka_exp;
    logic [FIELD_W-1:0]    w_field;
    logic [NIB_W-1:0]      w_fext;
    logic [3:0]            w_nib;
    logic [7:0]            w_char;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_gap_done && ((fields_in != r_last_sent) || r_force_pend || w_ka_exp))
                         w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_SEND;
            S_SEND:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte at r_idx is derived from the snapshot; r_fld/r_off track position inside the field list.
    always_comb begin
        w_field = '0;
        w_nib   = '0;
        w_char  = 8'h00;
        for (int i = 0; i < NUM_FIELDS; i++)
            if (r_fld == FLD_W'(i)) w_field = r_snap[i*FIELD_W +: FIELD_W];
        w_fext = NIB_W'(w_field);
        for (int j = 0; j < D; j++)
            if (r_off == OFF_W'(j + 2)) w_nib = w_fext[(D-1-j)*4 +: 4];

        if (r_idx == '0)                          w_char = 8'h24;
        else if (r_idx == IDX_W'(STAR_IDX))       w_char = 8'h2A;
        else if (r_idx == IDX_W'(STAR_IDX + 1))   w_char = f_hex(r_csum[7:4]);
        else if (r_idx == IDX_W'(STAR_IDX + 2))   w_char = f_hex(r_csum[3:0]);
        else if (r_idx == IDX_W'(STAR_IDX + 3))   w_char = 8'h0D;
        else if (r_idx == IDX_W'(STAR_IDX + 4))   w_char = 8'h0A;
        else if (r_off == '0)                     w_char = 8'h41 + 8'(r_fld);
        else if (r_off == OFF_W'(1))              w_char = 8'h3A;
        else if (r_off == OFF_W'(D + 2))          w_char = 8'h2C;
        else                                      w_char = f_hex(w_nib);

        w_wr_en    = (r_state == S_SEND) && tx_ready && !tx_full;
        w_last     = w_wr_en && (r_idx == IDX_W'(L - 1));
        w_csum_upd = (r_idx != '0) && (r_idx < IDX_W'(STAR_IDX));
        w_ka_exp   = (KEEPALIVE_CYCLES != 0) && (r_ka_cnt == KA_W'(KEEPALIVE_CYCLES));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap        <= '0;
            r_last_sent   <= '0;
            r_force_pend  <= 1'b0;
            r_idx         <= '0;
            r_off         <= '0;
            r_fld         <= '0;
            r_csum        <= '0;
            r_gap_cnt     <= '0;
            r_gap_done    <= 1'b1;
            r_ka_cnt      <= '0;
            r_uart_data   <= '0;
            r_uart_wr     <= 1'b0;
            r_busy        <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_uart_wr <= w_wr_en;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (r_state == S_LATCH) r_force_pend <= 1'b0;
            if (force_send)         r_force_pend <= 1'b1;

            if (r_state == S_LATCH) begin
                r_snap      <= fields_in;
                r_last_sent <= fields_in;
                r_idx       <= '0;
                r_off       <= '0;
                r_fld       <= '0;
                r_csum      <= '0;
            end

            if (w_wr_en) begin
                r_uart_data <= DATA_WIDTH'(w_char);
                r_idx       <= r_idx + IDX_W'(1);
                if (w_csum_upd) r_csum <= r_csum ^ w_char;
                if (r_idx != '0) begin
                    if (r_off == OFF_W'(D + 2)) begin
                        r_off <= '0;
                        r_fld <= r_fld + FLD_W'(1);
                    end else begin
                        r_off <= r_off + OFF_W'(1);
                    end
                end
            end

            if (w_last) begin
                r_frames_sent <= r_frames_sent + 16'd1;
                r_gap_cnt     <= '0;
                r_gap_done    <= (MIN_GAP_CYCLES == 0);
                r_ka_cnt      <= '0;
            end else if (r_state == S_IDLE) begin
                if (!r_gap_done) begin
                    r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    if (32'(r_gap_cnt) + 32'd1 >= MIN_GAP_CYCLES) r_gap_done <= 1'b1;
                end
                if ((KEEPALIVE_CYCLES != 0) && !w_ka_exp) r_ka_cnt <= r_ka_cnt + KA_W'(1);
            end
        end
    end

    assign uart_data   = r_uart_data;
    assign uart_wr     = r_uart_wr;
    assign busy        = r_busy;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_uart_frame_encoder.sv
// Scoreboard bench for uart_frame_encoder with two fields of 8 bits: one instance without
// keepalive for the directed sequence, one with a 50-cycle keepalive and static fields.
module tb_uart_frame_encoder;
    localparam int FL = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, force_send, tx_ready, tx_full;
    logic [15:0] fields_in;
    logic [7:0]  uart_data;
    logic        uart_wr, busy;
    logic [15:0] frames_sent;

    logic        rst_ka, ka_force, ka_ready, ka_full;
    logic [15:0] ka_fields;
    logic [7:0]  ka_data;
    logic        ka_wr, ka_busy;
    logic [15:0] ka_sent;

    uart_frame_encoder #(.NUM_FIELDS(2), .FIELD_W(8), .DATA_WIDTH(8),
                         .MIN_GAP_CYCLES(10), .KEEPALIVE_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .fields_in(fields_in), .force_send(force_send),
        .tx_ready(tx_ready), .tx_full(tx_full), .uart_data(uart_data),
        .uart_wr(uart_wr), .busy(busy), .frames_sent(frames_sent));

    uart_frame_encoder #(.NUM_FIELDS(2), .FIELD_W(8), .DATA_WIDTH(8),
                         .MIN_GAP_CYCLES(10), .KEEPALIVE_CYCLES(50)) dut_ka (
        .clk(clk), .rst(rst_ka), .fields_in(ka_fields), .force_send(ka_force),
        .tx_ready(ka_ready), .tx_full(ka_full), .uart_data(ka_data),
        .uart_wr(ka_wr), .busy(ka_busy), .frames_sent(ka_sent));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    // Reference frame for two 8-bit fields: field A = f[7:0], field B = f[15:8].
    function automatic logic [7:0] frame_byte(input logic [15:0] f, input int i);
        logic [7:0] cs;
        cs = 8'h41 ^ 8'h3A ^ hx(f[7:4]) ^ hx(f[3:0]) ^ 8'h2C ^ 8'h42 ^ 8'h3A ^ hx(f[15:12]) ^ hx(f[11:8]);
        case (i)
            0:  return 8'h24;
            1:  return 8'h41;
            2:  return 8'h3A;
            3:  return hx(f[7:4]);
            4:  return hx(f[3:0]);
            5:  return 8'h2C;
            6:  return 8'h42;
            7:  return 8'h3A;
            8:  return hx(f[15:12]);
            9:  return hx(f[11:8]);
            10: return 8'h2A;
            11: return hx(cs[7:4]);
            12: return hx(cs[3:0]);
            13: return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    logic [7:0] exp_q[$];

    function automatic void push_frame(input logic [15:0] f);
        for (int i = 0; i < FL; i++) exp_q.push_back(frame_byte(f, i));
    endfunction

    function automatic void push_literal(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Main-instance monitor: pops expected bytes and tracks frame boundaries.
    logic [7:0] eb;
    int  n_starts = 0, frm_bytes = 0, t_first = 0, t_lf = 0, last_span = 0;
    bit  have_lf = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            have_lf = 1'b0;
        end else if (uart_wr) begin
            chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                eb = exp_q.pop_front();
                chk("byte", 32'(uart_data), 32'(eb));
                if (eb == 8'h24) begin
                    if (have_lf) chk("min_gap", 32'((cyc - t_lf) >= 11), 32'd1);
                    n_starts++;
                    frm_bytes = 0;
                    t_first   = cyc;
                end
                frm_bytes++;
                if (eb == 8'h0A) begin
                    t_lf      = cyc;
                    have_lf   = 1'b1;
                    last_span = cyc - t_first;
                end
            end
        end
    end

    // Keepalive-instance monitor: every frame must equal the static-field frame.
    int ka_pos = 0, ka_frames = 0, ka_t_lf = 0;
    bit ka_have_lf = 1'b0;
    always @(negedge clk) begin
        if (rst_ka && ka_wr) begin
            chk("ka_byte", 32'(ka_data), 32'(frame_byte(16'h1234, ka_pos)));
            if (ka_pos == 0 && ka_have_lf)
                chk("ka_period", 32'(((cyc - ka_t_lf) >= 51) && ((cyc - ka_t_lf) <= 56)), 32'd1);
            if (ka_pos == FL - 1) begin
                ka_pos     = 0;
                ka_frames++;
                ka_t_lf    = cyc;
                ka_have_lf = 1'b1;
            end else begin
                ka_pos++;
            end
        end
    end

    task automatic wait_drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin @(negedge clk); k++; end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_bytes(input string tag, input int starts, input int nb);
        int k = 0;
        while (!(n_starts >= starts && frm_bytes >= nb) && k < 300) begin @(negedge clk); k++; end
        chk(tag, 32'(n_starts >= starts && frm_bytes >= nb), 32'd1);
    endtask

    task automatic wait_ka(input string tag, input int target);
        int k = 0;
        while (ka_frames < target && k < 300) begin @(negedge clk); k++; end
        chk(tag, 32'(ka_frames >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int f0;
    initial begin
        rst = 1'b0; fields_in = 16'h0000; force_send = 1'b0; tx_ready = 1'b1; tx_full = 1'b0;
        rst_ka = 1'b0; ka_fields = 16'h1234; ka_force = 1'b0; ka_ready = 1'b1; ka_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr", 32'(uart_wr), 32'd0);
        chk("rst_data", 32'(uart_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        @(negedge clk);
        rst = 1'b1; rst_ka = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_frames", 32'(frames_sent), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // First frame on field change, sent back to back
        fields_in = 16'h3FA5;
        push_literal("$A:A5,B:3F*2E");
        wait_drain("f1_drain");
        chk("f1_frames", 32'(frames_sent), 32'd1);
        chk("f1_span", 32'(last_span), 32'd14);
        chk("f1_busy", 32'(busy), 32'd0);

        // Forced resend with FIFO back-pressure mid-frame
        repeat (15) @(negedge clk);
        force_send = 1'b1;
        push_literal("$A:A5,B:3F*2E");
        @(negedge clk);
        force_send = 1'b0;
        wait_bytes("f2_bytes", 2, 6);
        tx_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("full_no_wr", 32'(uart_wr), 32'd0);
        end
        tx_full = 1'b0;
        wait_drain("f2_drain");
        chk("f2_frames", 32'(frames_sent), 32'd2);

        // Field change while a frame is in flight
        repeat (15) @(negedge clk);
        fields_in = 16'h5A3C;
        push_frame(16'h5A3C);
        wait_bytes("f3_bytes", 3, 3);
        fields_in = 16'h0001;
        push_frame(16'h0001);
        wait_drain("f34_drain");
        chk("f4_frames", 32'(frames_sent), 32'd4);

        // Three force pulses during the gap collapse into one frame
        push_frame(16'h0001);
        repeat (3) begin
            force_send = 1'b1;
            @(negedge clk);
            force_send = 1'b0;
            @(negedge clk);
        end
        wait_drain("f5_drain");
        repeat (40) @(negedge clk);
        chk("f5_frames", 32'(frames_sent), 32'd5);
        chk("f5_busy", 32'(busy), 32'd0);

        // Reset in the middle of a frame, then a fresh full frame
        fields_in = 16'h7E11;
        push_frame(16'h7E11);
        wait_bytes("f6_bytes", 6, 6);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(uart_wr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(uart_data), 32'd0);
        chk("mid_rst_frames", 32'(frames_sent), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_frame(16'h7E11);
        wait_drain("f7_drain");
        chk("f7_frames", 32'(frames_sent), 32'd1);

        // Keepalive repeats and frame counter wrap
        f0 = ka_frames;
        wait_ka("ka_next", f0 + 1);
        @(negedge clk);
        force dut_ka.r_frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut_ka.r_frames_sent;
        wait_ka("ka_wrap_frame", f0 + 2);
        chk("ka_wrap", 32'(ka_sent), 32'd0);
        wait_ka("ka_after_wrap", f0 + 3);
        chk("ka_after_wrap_cnt", 32'(ka_sent), 32'd1);
        chk("ka_repeats", 32'(ka_frames >= 4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_encoder.md
UART_FRAME_ENCODER -- requirements
Module: uart_frame_encoder

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 8: number of telemetry fields per frame (1..16).
REQ-002 SHALL have parameter FIELD_W, default 12: width of each field in bits (4..16); D = ceil(FIELD_W/4) hex digits per field.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: UART byte width.
REQ-004 SHALL have parameter MIN_GAP_CYCLES, default 6_500_000: minimum idle cycles from the last byte of one frame to the first byte of the next.
REQ-005 SHALL have parameter KEEPALIVE_CYCLES, default 65_000_000: idle cycles after which an unchanged frame is resent; 0 disables keepalive.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port fields_in, input, NUM_FIELDS*FIELD_W: field i at bits [i*FIELD_W +: FIELD_W].
REQ-009 SHALL have port force_send, input, 1: single-cycle request for a frame regardless of change.
REQ-010 SHALL have port tx_ready, input, 1: UART transmitter can accept a byte.
REQ-011 SHALL have port tx_full, input, 1: UART FIFO full; blocks writes.
REQ-012 SHALL have port uart_data, output, DATA_WIDTH: byte to transmit.
REQ-013 SHALL have port uart_wr, output, 1: one-cycle write strobe, qualifies uart_data.
REQ-014 SHALL have port busy, output, 1: high while in LATCH or SEND.
REQ-015 SHALL have port frames_sent, output, 16: count of completed frames, wraps from 0xFFFF to 0.

Function
REQ-016 Frame format SHALL be: '$'; per field i, the tag ('A'+i), ':', then D uppercase hex ASCII digits, MSB first (0-9 = 0x30-0x39, A-F = 0x41-0x46); ',' between fields, none after the last; '*'; two hex checksum digits; 0x0D; 0x0A.
REQ-017 Frame length SHALL be L = NUM_FIELDS*(D+3) + 5 bytes.
REQ-018 Checksum SHALL be the XOR of all bytes strictly between '$' and '*', emitted high nibble first.
REQ-019 FSM states SHALL be IDLE, LATCH and SEND.
REQ-020 IDLE->LATCH SHALL occur when gap_done and (fields_in != last_sent, or force pending, or keepalive expired).
REQ-021 LATCH SHALL last one cycle: copy fields_in into snapshot and last_sent, clear force pending, zero byte index and checksum, then go to SEND.
REQ-022 In SEND, in any cycle with tx_ready=1 and tx_full=0, the block SHALL drive uart_data = byte[index] with uart_wr=1 in the same registered cycle, then increment index; otherwise uart_wr=0 and index holds.
REQ-023 Bytes SHALL be generated on the fly from snapshot and index; no full-frame buffer.
REQ-024 After byte L-1 (0x0A) is written, the block SHALL increment frames_sent, clear the gap counter and return to IDLE; gap_done is set when the gap counter reaches MIN_GAP_CYCLES.
REQ-025 Snapshot SHALL be stable during SEND; fields_in changes during SEND SHALL NOT alter the frame in flight and are detected against last_sent after gap_done.
REQ-026 A force_send pulse in any state SHALL set force pending; multiple pulses before LATCH SHALL yield a single frame.
REQ-027 Keepalive counter SHALL count idle cycles since the last frame end, and expire at KEEPALIVE_CYCLES when that parameter is nonzero.
REQ-028 With MIN_GAP_CYCLES=0, the next frame SHALL be allowed to begin LATCH the cycle after returning to IDLE.

Reset
REQ-029 On rst=0 at any time, including mid-frame, the block SHALL immediately force state=IDLE, uart_wr=0, uart_data=0, busy=0, frames_sent=0, last_sent=0, snapshot=0, force pending=0 and keepalive counter=0, and set gap_done=1.
REQ-030 After release, the first frame SHALL start from byte 0; no partial frame is resumed.

Verification (NUM_FIELDS=2, FIELD_W=8, MIN_GAP_CYCLES=10, KEEPALIVE_CYCLES=0 unless noted)
REQ-031 Set fields_in=0x3FA5 after reset with tx_ready=1 and tx_full=0 -> 15 consecutive strobes carrying "$A:A5,B:3F*2E" followed by 0D 0A, and frames_sent=1.
REQ-032 Hold tx_full=1 for 5 cycles mid-frame -> no strobes during those cycles; byte order unchanged; checksum still 2E.
REQ-033 Change fields_in to 0x0001 during SEND -> current frame unchanged; next frame "$A:01,B:00*.." starts no earlier than 10 idle cycles after the preceding LF.
REQ-034 Pulse force_send 3 times with fields unchanged -> exactly one extra identical frame.
REQ-035 Assert rst=0 at byte 6 -> uart_wr=0 immediately; after release a complete fresh frame starting with '$' is sent.
REQ-036 Set KEEPALIVE_CYCLES=50 with static fields -> a frame is repeated every 50 idle cycles after the LF; frames_sent wraps 0xFFFF->0 when preloaded.
